// File: rtl/sift_window_sequencer.sv
// Shift/MAC enable, raster tracking and MAC-aligned centre tags for one vertical Gaussian stage.
// Define SIFT_SEQ_FLUSH_EN to add the end-of-frame FLUSH state that pads out the last rows.
module sift_window_sequencer #(
    parameter int FRAME_W = 200,
    parameter int FRAME_H = 200,
    parameter int DOWN_S  = 0,
    parameter int WIN     = 19,
    parameter int MAC_LAT = 3,
    parameter int CW      = 16
) (
    input  logic          pixClk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          en_p,
    output logic          pad_sel,
    output logic          out_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          border,
    output logic          busy,
    output logic          frame_done
);
    localparam int RADI = WIN / 2;
    localparam int W_DS = FRAME_W >> DOWN_S;
    localparam int H_DS = FRAME_H >> DOWN_S;
    localparam logic [CW-1:0] DS_MASK = CW'((1 << DOWN_S) - 1);
    localparam logic [CW-1:0] X_LAST  = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(FRAME_H - 1);
    localparam logic [CW-1:0] DX_LAST = CW'(W_DS - 1);
    localparam logic [CW-1:0] RADI_C  = CW'(RADI);
    localparam logic [CW-1:0] BRD_LO  = CW'(2 * RADI);
    localparam logic [CW-1:0] H_DS_C  = CW'(H_DS);
    localparam logic [CW-1:0] CY_END  = CW'(H_DS + RADI);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic          valid;
        logic          brd;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } tag_t;

    state_t        state;
    logic [CW-1:0] x, y, dx, dy;
    tag_t          pipe    [MAC_LAT];
    tag_t          shifted [MAC_LAT];
    tag_t          new_tag;
    logic          accept, last_pix, dec_hit;

`ifdef SIFT_SEQ_FLUSH_EN
    localparam int FLUSH_N = RADI * W_DS + MAC_LAT;
    localparam int FCW     = $clog2(FLUSH_N + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_N - 1);
    logic [FCW-1:0] fcnt;
`endif

    // Enables are combinational so they line up with the pixel currently on the bus.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        dec_hit   = ((x & DS_MASK) == '0) && ((y & DS_MASK) == '0);
        pix_ready = (state == RUN);
        accept    = pix_ready && pix_valid;
        last_pix  = accept && (x == X_LAST) && (y == Y_LAST);
        en_p      = accept && dec_hit;
        pad_sel   = 1'b0;
`ifdef SIFT_SEQ_FLUSH_EN
        if (state == FLUSH) begin
            en_p    = 1'b1;
            pad_sel = 1'b1;
        end
`endif
    end

    assign busy = (state == RUN) || (state == FLUSH);

    // The tag names the window centre, RADI rows above the row being shifted in.
    always_comb begin
        new_tag.valid = (dy >= RADI_C) && (dy < CY_END);
        new_tag.brd   = (dy < BRD_LO) || (dy >= H_DS_C);
        new_tag.x     = dx;
        new_tag.y     = dy - RADI_C;
        shifted[0]    = new_tag;
        for (int i = 1; i < MAC_LAT; i++) shifted[i] = pipe[i-1];
    end

    always_ff @(posedge pixClk) begin
        if (rst || frame_start) begin
            // NOTE: the tag pipe is reset like any control state; stale valid bits would leak old-frame outputs.
            for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
            state      <= rst ? IDLE : RUN;
            x          <= '0;
            y          <= '0;
            dx         <= '0;
            dy         <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SIFT_SEQ_FLUSH_EN
            fcnt       <= '0;
`endif
            if (rst) begin
                out_x  <= '0;
                out_y  <= '0;
                border <= 1'b0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (en_p) begin
                pipe      <= shifted;
                out_valid <= shifted[MAC_LAT-1].valid;
                out_x     <= shifted[MAC_LAT-1].x;
                out_y     <= shifted[MAC_LAT-1].y;
                border    <= shifted[MAC_LAT-1].brd;
                if (dx == DX_LAST) begin
                    dx <= '0;
                    dy <= dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end
            case (state)
                RUN: begin
                    if (last_pix) begin
`ifdef SIFT_SEQ_FLUSH_EN
                        state <= FLUSH;
`else
                        // Without a flush the pipe contents are abandoned, including this slot.
                        state      <= DONE;
                        frame_done <= 1'b1;
                        out_valid  <= 1'b0;
`endif
                    end
                end
`ifdef SIFT_SEQ_FLUSH_EN
                FLUSH: begin
                    fcnt <= fcnt + 1'b1;
                    if (fcnt == FLUSH_LAST) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sift_window_sequencer.sv
// Randomised bench for sift_window_sequencer: two configurations (8x6 full rate, 8x8 decimated)
// checked every cycle against a raster-index model, plus hand-derived per-frame literals.
module tb_sift_window_sequencer;
    int total = 0;
    int bad = 0;
    int fin_cnt = 0;
    logic clk = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int FW = 8;
        localparam int FH = (gi == 0) ? 6 : 8;
        localparam int DS = gi;
        localparam int WN = 5;
        localparam int L  = 3;
        localparam int R  = WN / 2;
        localparam int WD = FW >> DS;
        localparam int HD = FH >> DS;
        localparam int NFLUSH = R * WD + L;
`ifdef SIFT_SEQ_FLUSH_EN
        localparam bit FLUSH_ON = 1'b1;
`else
        localparam bit FLUSH_ON = 1'b0;
`endif
        // Hand-derived per-frame results: first-output strobe, output count, border count, last coordinate.
        localparam int EXP_FIRST = (gi == 0) ? 19 : 11;
        localparam int EXP_N  = FLUSH_ON ? ((gi == 0) ? 48 : 16) : ((gi == 0) ? 29 : 6);
        localparam int EXP_NB = FLUSH_ON ? ((gi == 0) ? 32 : 16) : ((gi == 0) ? 16 : 6);
        localparam int EXP_LX = FLUSH_ON ? ((gi == 0) ? 7 : 3) : ((gi == 0) ? 4 : 1);
        localparam int EXP_LY = FLUSH_ON ? ((gi == 0) ? 5 : 3) : ((gi == 0) ? 3 : 1);

        logic        rst = 1'b1;
        logic        frame_start = 1'b0;
        logic        pix_valid = 1'b0;
        logic        pix_ready, en_p, pad_sel, out_valid, border, busy, frame_done;
        logic [15:0] out_x, out_y;

        sift_window_sequencer #(
            .FRAME_W(FW), .FRAME_H(FH), .DOWN_S(DS), .WIN(WN), .MAC_LAT(L), .CW(16)
        ) dut (
            .pixClk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
            .pix_ready(pix_ready), .en_p(en_p), .pad_sel(pad_sel), .out_valid(out_valid),
            .out_x(out_x), .out_y(out_y), .border(border), .busy(busy), .frame_done(frame_done)
        );

        // Model: phase (0 idle, 1 run, 2 flush, 3 done), pixels accepted, strobes issued, flush strobes.
        int   mode = 0;
        int   np = 0;
        int   nj = 0;
        int   nf = 0;
        logic e_ov = 1'b0;
        logic e_fd = 1'b0;
        logic e_brd = 1'b0;
        int   e_x = 0;
        int   e_y = 0;
        // Per-frame observations of the DUT, compared with the literals above.
        int   st_strobes = 0;
        int   st_first = -1;
        int   st_n = 0;
        int   st_nb = 0;
        int   st_lx = -1;
        int   st_ly = -1;
        bit   fd_seen = 1'b0;

        // Strobe number nj emits the tag of strobe nj-(L-1); that tag's centre row is its row minus R.
        task automatic strobe(input bit drop);
            int t  = nj - (L - 1);
            int cy = t / WD - R;
            e_ov  = (t >= 0) && (cy >= 0) && (cy < HD) && !drop;
            e_x   = t % WD;
            e_y   = cy;
            e_brd = (cy < R) || (cy > HD - 1 - R);
            nj++;
        endtask

        always @(negedge clk) begin
            bit ready, acc, en, last;
            ready = (mode == 1);
            acc   = ready && pix_valid;
            en    = (acc && ((np % FW) % (1 << DS) == 0) && ((np / FW) % (1 << DS) == 0)) || (mode == 2);
            check($sformatf("g%0d pix_ready", gi), pix_ready, ready);
            check($sformatf("g%0d en_p", gi), en_p, en);
            check($sformatf("g%0d pad_sel", gi), pad_sel, mode == 2);
            check($sformatf("g%0d busy", gi), busy, (mode == 1) || (mode == 2));
            check($sformatf("g%0d out_valid", gi), out_valid, e_ov);
            check($sformatf("g%0d frame_done", gi), frame_done, e_fd);
            if (e_ov) begin
                check($sformatf("g%0d out_x", gi), out_x, e_x);
                check($sformatf("g%0d out_y", gi), out_y, e_y);
                check($sformatf("g%0d border", gi), border, e_brd);
            end

            if (out_valid) begin
                if (st_first < 0) st_first = st_strobes;
                st_n++;
                st_nb += int'(border);
                st_lx = int'(out_x);
                st_ly = int'(out_y);
            end
            if (en_p) st_strobes++;
            if (frame_done) fd_seen = 1'b1;

            last = acc && (np == FW * FH - 1);
            e_ov = 1'b0;
            e_fd = 1'b0;
            if (rst) begin
                mode = 0;
            end else if (frame_start) begin
                mode = 1;
                np = 0;
                nj = 0;
                nf = 0;
                st_strobes = 0;
                st_first = -1;
                st_n = 0;
                st_nb = 0;
                st_lx = -1;
                st_ly = -1;
            end else begin
                case (mode)
                    1: begin
                        if (en) strobe(last && !FLUSH_ON);
                        if (acc) np++;
                        if (last) begin
                            if (FLUSH_ON) mode = 2;
                            else begin
                                mode = 3;
                                e_fd = 1'b1;
                            end
                        end
                    end
                    2: begin
                        strobe(1'b0);
                        nf++;
                        if (nf == NFLUSH) begin
                            mode = 3;
                            e_fd = 1'b1;
                        end
                    end
                    3: mode = 0;
                    default: ;
                endcase
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        // gap: 0 continuous, 1 toggling, 2 random. abort_at >= 0 restarts after that many accepted pixels.
        task automatic run_frame(input int gap, input int abort_at);
            int acc_cnt = 0;
            bit aborted = 1'b0;
            bit ok = 1'b0;
            frame_start = 1'b1;
            pix_valid = ($urandom_range(0, 1) == 1);
            fd_seen = 1'b0;
            step();
            frame_start = 1'b0;
            for (int k = 0; k < 2000 && !ok; k++) begin
                case (gap)
                    0:       pix_valid = 1'b1;
                    1:       pix_valid = (k % 2 == 0);
                    default: pix_valid = ($urandom_range(0, 3) != 0);
                endcase
                if (abort_at >= 0 && !aborted && acc_cnt == abort_at) begin
                    frame_start = 1'b1;
                    aborted = 1'b1;
                end
                @(negedge clk);
                if (pix_ready && pix_valid && !frame_start) acc_cnt++;
                ok = fd_seen;
                step();
                frame_start = 1'b0;
            end
            pix_valid = 1'b0;
            step();
            step();
            check($sformatf("g%0d frame_done reached (gap %0d)", gi, gap), fd_seen, 1'b1);
            check($sformatf("g%0d first output strobe", gi), st_first, EXP_FIRST);
            check($sformatf("g%0d output count", gi), st_n, EXP_N);
            check($sformatf("g%0d border count", gi), st_nb, EXP_NB);
            check($sformatf("g%0d last x", gi), st_lx, EXP_LX);
            check($sformatf("g%0d last y", gi), st_ly, EXP_LY);
        endtask

        task automatic reset_mid_frame();
            int k = 0;
            frame_start = 1'b1;
            pix_valid = 1'b1;
            step();
            frame_start = 1'b0;
            while (k < 500 && !(FLUSH_ON ? (mode == 2 && nf == 3) : (np == 25))) begin
                step();
                k++;
            end
            check($sformatf("g%0d reached reset point", gi), k < 500, 1'b1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            @(negedge clk);
            check($sformatf("g%0d post-reset out_valid", gi), out_valid, 1'b0);
            check($sformatf("g%0d post-reset out_x", gi), out_x, 16'd0);
            check($sformatf("g%0d post-reset out_y", gi), out_y, 16'd0);
            check($sformatf("g%0d post-reset border", gi), border, 1'b0);
            check($sformatf("g%0d post-reset busy", gi), busy, 1'b0);
            step();
            repeat (6) step();
            @(negedge clk);
            check($sformatf("g%0d idle without frame_start", gi), pix_ready, 1'b0);
            pix_valid = 1'b0;
            step();
        endtask

        initial begin
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("g%0d reset out_valid", gi), out_valid, 1'b0);
            check($sformatf("g%0d reset out_x", gi), out_x, 16'd0);
            check($sformatf("g%0d reset frame_done", gi), frame_done, 1'b0);
            check($sformatf("g%0d reset busy", gi), busy, 1'b0);
            rst = 1'b0;
            step();
            run_frame(0, -1);
            run_frame(1, -1);
            run_frame(2, -1);
            run_frame(0, 20);
            reset_mid_frame();
            run_frame(2, -1);
            fin_cnt++;
        end
    end

    initial begin
        int cyc = 0;
        while (fin_cnt < 2 && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        check("all scenarios finished", fin_cnt, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
